nand_reduce_pipe: RTL and testbench
===================================

# nand_reduce_pipe

Parametrised, pipelined successor to the fixed four-input NAND macro in the schematic-capture library. It reduces WIDTH inputs per channel, for CHANNELS independent channels, through a registered fan-in tree. A per-beat MODE selects NAND/AND/NOR/OR/XOR/XNOR. Valid tagging and a clock enable allow the block to sit in a datapath between registered schematic macros.

## Interface
Parameters:
- WIDTH, 4: inputs reduced per channel; legal 2..64.
- CHANNELS, 1: independent reduction channels; legal 1..16.
- FANIN, 4: maximum inputs combined per pipeline stage; legal 2..8.

Ports:
- CK  in  1  clock; all state changes on its rising edge.
- CD  in  1  reset; asynchronous, active-high. Clears every register immediately.
- CE  in  1  clock enable; when low, the whole pipeline holds.
- VI  in  1  input beat valid.
- MODE  in  3  reduction for this beat: 000 NAND, 001 AND, 010 NOR, 011 OR, 100 XOR, 101 XNOR. 110 and 111 are reserved and execute as NAND.
- A  in  CHANNELS*WIDTH  data; channel c occupies bits [c*WIDTH +: WIDTH].
- ZN  out  CHANNELS  result; bit c is the reduction of channel c.
- VO  out  1  ZN holds a valid result.

## Operation
- Stage count: S = ceil(log_FANIN(WIDTH)), minimum 1. For example, WIDTH=4/FANIN=4 gives S=1, WIDTH=16/FANIN=4 gives S=2, and WIDTH=5/FANIN=4 gives S=2.
- Each stage combines up to FANIN values from the previous stage using the base operator (AND, OR or XOR) and registers the result.
- Padding: when a group has fewer than FANIN members, it is padded with the identity element, 1 for the AND family and 0 for the OR/XOR family. Padding never changes the result.
- MODE is decoded at the input into a base-op code and an invert bit. Both travel with the beat through the pipeline.
  - Consecutive beats may use different modes without any bubble.
  - Inversion is applied only in the final stage.
- VI is registered alongside the data in every stage, and VO is the last stage's valid bit.
- Data registers load regardless of VI, so the data path needs no gating. When VO=0, ZN is don't-care but deterministic: the reduction of whatever was sampled.
- CE=0: no register in any stage changes, including the valid bits. A beat presented while CE=0 is not captured.
- Channels share the valid, mode and CE controls and never interact in data.

## Timing
- Latency: S cycles. A beat sampled on edge k (with CE=1) appears on ZN/VO after edge k+S-1. Only edges with CE=1 count.
- Throughput: one beat per CE=1 cycle.
- Reset values:
  - ZN=0 for all channels.
  - VO=0.
  - All stage valids, mode bits and data registers are 0.
- Reset mid-operation: every in-flight beat is discarded. The first beat after CD falls is sampled on the first rising edge with CE=1, and no stale VO can appear.
- CD has priority over CE.
- Simultaneous events:
  - CE=0 together with a MODE change: nothing happens.
  - VI=1 on the same edge that CD deasserts: that beat is not captured.

## Structure
- Shared package `macro_pkg` holds:
  - mode encodings (MODE_NAND..MODE_XNOR);
  - base-op enum {OP_AND, OP_OR, OP_XOR};
  - function `clog_fanin(width, fanin)` for computing S;
  - function `op_identity(op)`.
- One sub-module, `reduce_stage`, instantiated S times via a generate loop. Parameters are IN_W and FANIN; it provides registered combine, valid, op and invert, plus the CE hold.
- The top level handles MODE decode, channel slicing and final inversion.

## Test plan
- WIDTH=4, FANIN=4, CHANNELS=1, MODE=000. A=4'b1111 then 4'b1011 on consecutive beats gives ZN=0 then 1, each with VO=1 one edge after capture.
- WIDTH=16, FANIN=4, CHANNELS=2. Ch0=16'hFFFF and ch1=16'hFFFE, with modes alternating AND/NAND each beat:
  - ZN for the AND beat = 2'b01;
  - ZN for the NAND beat = 2'b10;
  - latency is 2 with no bubbles.
- WIDTH=5, FANIN=4 padding check. A=5'b11111 gives AND=1, OR=1, XOR=1. A=5'b00000 gives NOR=1.
- CE toggled 1,0,0,1 during a WIDTH=16 stream: VO and ZN freeze for two cycles, then resume with no lost or duplicated beat. The count of VO pulses must equal the count of beats captured with CE=1.
- CD asserted asynchronously mid-cycle while two beats are in flight: ZN=0 and VO=0 immediately, with no VO pulse in the S cycles after release unless a new VI beat is captured.
- MODE=3'b111 with A all ones gives ZN=0, identical to NAND.

Source files
------------

// File: rtl/macro_pkg.sv
// Shared definitions for the pipelined reduction macros: mode codes, base ops
// and the elaboration helpers that size the fan-in tree.
package macro_pkg;

   localparam logic [2:0] MODE_NAND = 3'b000;
   localparam logic [2:0] MODE_AND  = 3'b001;
   localparam logic [2:0] MODE_NOR  = 3'b010;
   localparam logic [2:0] MODE_OR   = 3'b011;
   localparam logic [2:0] MODE_XOR  = 3'b100;
   localparam logic [2:0] MODE_XNOR = 3'b101;

   typedef enum logic [1:0] {
      OP_AND = 2'd0,
      OP_OR  = 2'd1,
      OP_XOR = 2'd2
   } base_op_t;

   // Number of registered stages needed to fold width inputs down to one.
   function automatic int clog_fanin(input int width, input int fanin);
      int s;
      int w;
      s = 0;
      w = width;
      while (w > 1) begin
         w = (w + fanin - 1) / fanin;
         s++;
      end
      return (s < 1) ? 1 : s;
   endfunction

   // Vector width seen at the input of stage n.
   function automatic int stage_width(input int width, input int fanin, input int n);
      int w;
      w = width;
      for (int j = 0; j < n; j++) w = (w + fanin - 1) / fanin;
      return w;
   endfunction

   function automatic logic op_identity(input base_op_t op);
      return (op == OP_AND);
   endfunction

   function automatic logic op_combine(input base_op_t op, input logic x, input logic y);
      case (op)
         OP_AND:  return x & y;
         OP_OR:   return x | y;
         default: return x ^ y;
      endcase
   endfunction

endpackage

// File: rtl/reduce_stage.sv
// One registered level of the reduction tree: folds groups of FANIN bits per channel.
// Latency 1 enabled edge; the whole stage holds while ce is low.
module reduce_stage
   import macro_pkg::*;
#(
   parameter int IN_W     = 4,
   parameter int FANIN    = 4,
   parameter int CHANNELS = 1
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      ce,
   input  logic                                      vi,
   input  base_op_t                                  op,
   input  logic                                      inv,
   input  logic [CHANNELS*IN_W-1:0]                  din,
   output logic                                      vo,
   output base_op_t                                  op_q,
   output logic                                      inv_q,
   output logic [CHANNELS*((IN_W+FANIN-1)/FANIN)-1:0] dout
);

   localparam int OUT_W = (IN_W + FANIN - 1) / FANIN;

   logic [CHANNELS*OUT_W-1:0] comb;
   logic                      acc;

   // Short last group is filled with the op's identity so it never skews the result.
   always_comb begin
      comb = '0;
      acc  = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
         for (int g = 0; g < OUT_W; g++) begin
            acc = op_identity(op);
            for (int k = 0; k < FANIN; k++) begin
               if (g * FANIN + k < IN_W)
                  acc = op_combine(op, acc, din[c*IN_W + g*FANIN + k]);
               else
                  acc = op_combine(op, acc, op_identity(op));
            end
            comb[c*OUT_W + g] = acc;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vo    <= 1'b0;
         op_q  <= OP_AND;
         inv_q <= 1'b0;
         dout  <= '0;
      end else if (ce) begin
         vo    <= vi;
         op_q  <= op;
         inv_q <= inv;
         dout  <= comb;
      end
   end

endmodule

// File: rtl/nand_reduce_pipe.sv
// Pipelined multi-channel NAND/AND/NOR/OR/XOR/XNOR reduction; latency S = ceil(log_FANIN(WIDTH)).
// No backpressure: one beat per CE=1 edge, CE=0 freezes every stage.
module nand_reduce_pipe
   import macro_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int CHANNELS = 1,
   parameter int FANIN    = 4
) (
   input  logic                      CK,
   input  logic                      CD,
   input  logic                      CE,
   input  logic                      VI,
   input  logic [2:0]                MODE,
   input  logic [CHANNELS*WIDTH-1:0] A,
   output logic [CHANNELS-1:0]       ZN,
   output logic                      VO
);

   localparam int S = clog_fanin(WIDTH, FANIN);

   base_op_t dec_op;
   logic     dec_inv;

   // Reserved codes fall through to NAND.
   always_comb begin
      dec_op  = OP_AND;
      dec_inv = 1'b1;
      case (MODE)
         MODE_AND:  begin dec_op = OP_AND; dec_inv = 1'b0; end
         MODE_NOR:  begin dec_op = OP_OR;  dec_inv = 1'b1; end
         MODE_OR:   begin dec_op = OP_OR;  dec_inv = 1'b0; end
         MODE_XOR:  begin dec_op = OP_XOR; dec_inv = 1'b0; end
         MODE_XNOR: begin dec_op = OP_XOR; dec_inv = 1'b1; end
         default:   begin dec_op = OP_AND; dec_inv = 1'b1; end
      endcase
   end

   for (genvar i = 0; i < S; i++) begin : g_stg
      localparam int IW = stage_width(WIDTH, FANIN, i);
      localparam int OW = stage_width(WIDTH, FANIN, i + 1);

      logic                 vi_s;
      base_op_t             op_s;
      logic                 inv_s;
      logic [CHANNELS*IW-1:0] din_s;
      logic                 v;
      base_op_t             op;
      logic                 inv;
      logic [CHANNELS*OW-1:0] dat;

      if (i == 0) begin : g_in
         assign vi_s  = VI;
         assign op_s  = dec_op;
         assign inv_s = dec_inv;
         assign din_s = A;
      end else begin : g_chain
         assign vi_s  = g_stg[i-1].v;
         assign op_s  = g_stg[i-1].op;
         assign inv_s = g_stg[i-1].inv;
         assign din_s = g_stg[i-1].dat;
      end

      reduce_stage #(
         .IN_W     (IW),
         .FANIN    (FANIN),
         .CHANNELS (CHANNELS)
      ) u_stage (
         .clk   (CK),
         .rst   (CD),
         .ce    (CE),
         .vi    (vi_s),
         .op    (op_s),
         .inv   (inv_s),
         .din   (din_s),
         .vo    (v),
         .op_q  (op),
         .inv_q (inv),
         .dout  (dat)
      );
   end

   // The op code has no consumer past the last stage.
   logic unused_last_op;
   assign unused_last_op = ^g_stg[S-1].op;

   assign ZN = g_stg[S-1].dat ^ {CHANNELS{g_stg[S-1].inv}};
   assign VO = g_stg[S-1].v;

endmodule

// File: tb/tb_nand_reduce_pipe.sv
// Directed bench for nand_reduce_pipe: three instances cover the 4/16/5-input shapes,
// sharing controls; each check looks only at the instance that a vector targets.
module tb_nand_reduce_pipe;

   logic        ck = 1'b0;
   logic        cd, ce, vi;
   logic [2:0]  mode;
   logic [3:0]  a4;
   logic [31:0] a16;
   logic [4:0]  a5;
   logic        zn4, zn5;
   logic [1:0]  zn16;
   logic        vo4, vo16, vo5;
   int          checks = 0;
   int          errors = 0;
   int          vo_cnt;

   always #5 ck = ~ck;

   nand_reduce_pipe #(.WIDTH(4), .CHANNELS(1), .FANIN(4)) u_w4 (
      .CK(ck), .CD(cd), .CE(ce), .VI(vi), .MODE(mode), .A(a4), .ZN(zn4), .VO(vo4));
   nand_reduce_pipe #(.WIDTH(16), .CHANNELS(2), .FANIN(4)) u_w16 (
      .CK(ck), .CD(cd), .CE(ce), .VI(vi), .MODE(mode), .A(a16), .ZN(zn16), .VO(vo16));
   nand_reduce_pipe #(.WIDTH(5), .CHANNELS(1), .FANIN(4)) u_w5 (
      .CK(ck), .CD(cd), .CE(ce), .VI(vi), .MODE(mode), .A(a5), .ZN(zn5), .VO(vo5));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge ck);
      #1;
   endtask

   task automatic flush;
      vi = 1'b0;
      ce = 1'b1;
      repeat (3) step();
   endtask

   initial begin
      cd = 1'b1; ce = 1'b1; vi = 1'b0; mode = 3'b000;
      a4 = '0; a16 = '0; a5 = '0;
      repeat (2) step();
      chk("rst_zn4", zn4, 0);   chk("rst_vo4", vo4, 0);
      chk("rst_zn16", zn16, 0); chk("rst_vo16", vo16, 0);
      chk("rst_zn5", zn5, 0);   chk("rst_vo5", vo5, 0);
      #3 cd = 1'b0;

      // 4-input, single stage: result visible right after the capture edge
      vi = 1'b1; mode = 3'b000; a4 = 4'b1111; step();
      chk("w4_nand_1111_zn", zn4, 0); chk("w4_nand_1111_vo", vo4, 1);
      a4 = 4'b1011; step();
      chk("w4_nand_1011_zn", zn4, 1); chk("w4_nand_1011_vo", vo4, 1);
      mode = 3'b111; a4 = 4'b1111; step();
      chk("w4_rsv111_zn", zn4, 0);
      mode = 3'b110; a4 = 4'b0000; step();
      chk("w4_rsv110_zn", zn4, 1);
      mode = 3'b101; a4 = 4'b1011; step();
      chk("w4_xnor_zn", zn4, 0);
      mode = 3'b011; a4 = 4'b0000; step();
      chk("w4_or_zn", zn4, 0);
      mode = 3'b010; a4 = 4'b0100; step();
      chk("w4_nor_zn", zn4, 0);
      mode = 3'b100; a4 = 4'b0111; step();
      chk("w4_xor_zn", zn4, 1);
      vi = 1'b0; step();
      chk("w4_idle_vo", vo4, 0);
      flush();

      // 16-input, two channels, AND/NAND back to back
      vi = 1'b1; a16 = {16'hFFFE, 16'hFFFF}; mode = 3'b001; step();
      chk("w16_fill_vo", vo16, 0);
      mode = 3'b000; step();
      chk("w16_and_vo", vo16, 1); chk("w16_and_zn", zn16, 2'b01);
      vi = 1'b0; mode = 3'b001; step();
      chk("w16_nand_vo", vo16, 1); chk("w16_nand_zn", zn16, 2'b10);
      step();
      chk("w16_drain_vo", vo16, 0);
      flush();

      // 5-input: last group is one real bit plus three pad bits
      vi = 1'b1; a5 = 5'b11111; mode = 3'b001; step();
      chk("w5_fill_vo", vo5, 0);
      mode = 3'b011; step();
      chk("w5_and_zn", zn5, 1); chk("w5_and_vo", vo5, 1);
      mode = 3'b100; step();
      chk("w5_or_zn", zn5, 1);
      a5 = 5'b00000; mode = 3'b010; step();
      chk("w5_xor_zn", zn5, 1);
      a5 = 5'b10000; mode = 3'b001; step();
      chk("w5_nor_zn", zn5, 1);
      a5 = 5'b10000; mode = 3'b100; step();
      chk("w5_and_10000_zn", zn5, 0);
      vi = 1'b0; step();
      chk("w5_xor_10000_zn", zn5, 1); chk("w5_xor_10000_vo", vo5, 1);
      step();
      chk("w5_drain_vo", vo5, 0);
      flush();

      // CE hold in the middle of a 16-input stream
      vo_cnt = 0;
      vi = 1'b1; mode = 3'b011; a16 = {16'h0000, 16'h0001}; step();
      chk("ce_fill_vo", vo16, 0);
      a16 = {16'h0001, 16'h0000}; step();
      vo_cnt += int'(vo16);
      chk("ce_b1_zn", zn16, 2'b01); chk("ce_b1_vo", vo16, 1);
      ce = 1'b0; mode = 3'b000; a16 = {16'h0001, 16'h0001}; step();
      chk("ce_hold1_zn", zn16, 2'b01); chk("ce_hold1_vo", vo16, 1);
      step();
      chk("ce_hold2_zn", zn16, 2'b01); chk("ce_hold2_vo", vo16, 1);
      ce = 1'b1; mode = 3'b011; a16 = {16'h0000, 16'h0000}; step();
      vo_cnt += int'(vo16);
      chk("ce_b2_zn", zn16, 2'b10); chk("ce_b2_vo", vo16, 1);
      vi = 1'b0; step();
      vo_cnt += int'(vo16);
      chk("ce_b3_zn", zn16, 2'b00); chk("ce_b3_vo", vo16, 1);
      repeat (2) begin
         step();
         vo_cnt += int'(vo16);
      end
      chk("ce_vo_count", vo_cnt, 3);
      flush();

      // Asynchronous reset with two beats in flight, asserted while CE is low
      vi = 1'b1; mode = 3'b000; a16 = {16'hFFFE, 16'h0000}; step();
      a16 = {16'hFFFF, 16'hFFFF}; step();
      chk("rst_pre_zn", zn16, 2'b11); chk("rst_pre_vo", vo16, 1);
      #2 ce = 1'b0; cd = 1'b1;
      #1;
      chk("rst_async_zn", zn16, 0); chk("rst_async_vo", vo16, 0);
      vi = 1'b0; step();
      #3 cd = 1'b0; ce = 1'b1;
      for (int n = 0; n < 3; n++) begin
         step();
         chk($sformatf("rst_after_vo%0d", n), vo16, 0);
      end
      chk("rst_after_zn", zn16, 0);
      vi = 1'b1; mode = 3'b001; a16 = {16'hFFFF, 16'h0000}; step();
      chk("rst_new_fill_vo", vo16, 0);
      vi = 1'b0; step();
      chk("rst_new_vo", vo16, 1); chk("rst_new_zn", zn16, 2'b10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
